flash_test_gen: RTL and testbench

FLASH_TEST_GEN -- requirements
Module: flash_test_gen

---
 rtl/flash_test_gen_if.sv | 41 ++++
 rtl/flash_test_gen.sv | 137 +++++++++++++
 tb/tb_flash_test_gen.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_test_gen_if.sv
// rtl/flash_test_gen_if.sv - operation, write-stream, read-stream and status bundle for flash_test_gen
interface flash_test_gen_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8,
  parameter int NUM_W  = 9,
  parameter int ERR_W  = 16
);
  logic              i_start;
  logic [1:0]        o_op_type;
  logic [ADDR_W-1:0] o_op_addr;
  logic [NUM_W-1:0]  o_op_num;
  logic              o_op_valid;
  logic              i_op_ready;
  logic [DATA_W-1:0] o_wr_data;
  logic              o_wr_sop;
  logic              o_wr_eop;
  logic              o_wr_valid;
  logic              i_wr_ready;
  logic [DATA_W-1:0] i_rd_data;
  logic              i_rd_sop;
  logic              i_rd_eop;
  logic              i_rd_valid;
  logic              o_busy;
  logic              o_done;
  logic              o_pass;
  logic [ERR_W-1:0]  o_err_cnt;

  modport master (
    input  i_start, i_op_ready, i_wr_ready, i_rd_data, i_rd_sop, i_rd_eop, i_rd_valid,
    output o_op_type, o_op_addr, o_op_num, o_op_valid,
    output o_wr_data, o_wr_sop, o_wr_eop, o_wr_valid,
    output o_busy, o_done, o_pass, o_err_cnt
  );

  modport slave (
    output i_start, i_op_ready, i_wr_ready, i_rd_data, i_rd_sop, i_rd_eop, i_rd_valid,
    input  o_op_type, o_op_addr, o_op_num, o_op_valid,
    input  o_wr_data, o_wr_sop, o_wr_eop, o_wr_valid,
    input  o_busy, o_done, o_pass, o_err_cnt
  );
endinterface

// File: rtl/flash_test_gen.sv
// rtl/flash_test_gen.sv - erase/write/read-verify pattern generator for a flash controller
module flash_test_gen #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8,
  parameter int NUM_W  = 9,
  parameter int BURST  = 256,
  parameter int PASSES = 4,
  parameter int SECTOR = 4096,
  parameter int ERR_W  = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  flash_test_gen_if.master bus
);
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int JW = NUM_W + 1;
  localparam logic [PW-1:0]     LAST_P  = PW'(PASSES - 1);
  localparam logic [NUM_W-1:0]  BURST_N = NUM_W'(BURST);
  localparam logic [NUM_W-1:0]  LAST_K  = NUM_W'(BURST - 1);
  localparam logic [JW-1:0]     BURST_J = JW'(BURST);
  localparam logic [JW-1:0]     LAST_J  = JW'(BURST - 1);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(SECTOR);

  typedef enum logic [2:0] {
    IDLE, ERASE_OP, WRITE_OP, WRITE_DATA, READ_OP, READ_CHECK, FINISH
  } state_t;

  state_t            state, state_next;
  logic [PW-1:0]     p;
  logic [ADDR_W-1:0] base;
  logic [NUM_W-1:0]  k;
  logic [JW-1:0]     j;
  logic              op_valid_q, busy_q, done_q, pass_q;
  logic [ERR_W-1:0]  err_q;

  logic              in_op, op_fire, wr_fire, last_beat, rd_beat;
  logic [JW-1:0]     j_cur;
  logic [DATA_W-1:0] rd_exp;
  logic [1:0]        err_inc;
  logic [ERR_W:0]    err_sum;
  logic [ERR_W-1:0]  err_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_op      = (state == ERASE_OP) || (state == WRITE_OP) || (state == READ_OP);
    op_fire    = op_valid_q && bus.i_op_ready;
    wr_fire    = (state == WRITE_DATA) && bus.i_wr_ready;
    last_beat  = (k == LAST_K);
    rd_beat    = (state == READ_CHECK) && bus.i_rd_valid;
    j_cur      = bus.i_rd_sop ? '0 : j;
    rd_exp     = DATA_W'(p) + DATA_W'(j_cur);
    // Data and overrun errors share one count; a short/long eop adds a second.
    err_inc    = 2'd0;
    if (rd_beat) begin
      if ((bus.i_rd_data != rd_exp) || (j_cur >= BURST_J)) err_inc = 2'd1;
      if (bus.i_rd_eop && (j_cur != LAST_J))               err_inc = err_inc + 2'd1;
    end
    err_sum  = {1'b0, err_q} + (ERR_W+1)'(err_inc);
    err_next = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    case (state)
      IDLE:       if (bus.i_start)         state_next = ERASE_OP;
      ERASE_OP:   if (op_fire)             state_next = WRITE_OP;
      WRITE_OP:   if (op_fire)             state_next = WRITE_DATA;
      WRITE_DATA: if (wr_fire && last_beat) state_next = READ_OP;
      READ_OP:    if (op_fire)             state_next = READ_CHECK;
      READ_CHECK: if (rd_beat && bus.i_rd_eop)
                    state_next = (p == LAST_P) ? FINISH : ERASE_OP;
      FINISH:     state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      p          <= '0;
      base       <= '0;
      k          <= '0;
      j          <= '0;
    end else begin
      // The cycle after a handshake always has op_valid low, even between ops.
      op_valid_q <= ((state_next == ERASE_OP) || (state_next == WRITE_OP) ||
                     (state_next == READ_OP)) && !op_fire;
      done_q     <= 1'b0;
      case (state)
        IDLE: if (bus.i_start) begin
          busy_q <= 1'b1;
          pass_q <= 1'b0;
          err_q  <= '0;
          p      <= '0;
          base   <= '0;
          k      <= '0;
          j      <= '0;
        end
        WRITE_DATA: if (wr_fire) k <= last_beat ? '0 : k + 1'b1;
        READ_OP:    j <= '0;
        READ_CHECK: if (rd_beat) begin
          err_q <= err_next;
          j     <= (j_cur == '1) ? j_cur : j_cur + 1'b1;
          if (bus.i_rd_eop) begin
            if (p == LAST_P) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= (err_next == '0);
            end else begin
              p    <= p + 1'b1;
              base <= base + STEP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_op_valid = op_valid_q;
  assign bus.o_op_type  = (state == ERASE_OP) ? 2'b10 : (state == WRITE_OP) ? 2'b01 : 2'b00;
  assign bus.o_op_addr  = in_op ? base : '0;
  assign bus.o_op_num   = ((state == WRITE_OP) || (state == READ_OP)) ? BURST_N : '0;
  assign bus.o_wr_valid = (state == WRITE_DATA);
  assign bus.o_wr_data  = (state == WRITE_DATA) ? DATA_W'(p) + DATA_W'(k) : '0;
  assign bus.o_wr_sop   = (state == WRITE_DATA) && (k == '0);
  assign bus.o_wr_eop   = (state == WRITE_DATA) && last_beat;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_pass     = pass_q;
  assign bus.o_err_cnt  = err_q;
endmodule

// File: tb/tb_flash_test_gen.sv
// tb/tb_flash_test_gen.sv - directed self-checking bench for flash_test_gen
module tb_flash_test_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, op_ready, wr_ready, rd_sop, rd_eop, rd_valid;
  logic [7:0] rd_data;

  flash_test_gen_if #(.ADDR_W(24), .DATA_W(8), .NUM_W(9), .ERR_W(16)) f1();
  flash_test_gen_if #(.ADDR_W(24), .DATA_W(8), .NUM_W(9), .ERR_W(2))  f2();

  assign f1.i_start = start;    assign f2.i_start = start;
  assign f1.i_op_ready = op_ready; assign f2.i_op_ready = op_ready;
  assign f1.i_wr_ready = wr_ready; assign f2.i_wr_ready = wr_ready;
  assign f1.i_rd_data = rd_data;   assign f2.i_rd_data = rd_data;
  assign f1.i_rd_sop = rd_sop;     assign f2.i_rd_sop = rd_sop;
  assign f1.i_rd_eop = rd_eop;     assign f2.i_rd_eop = rd_eop;
  assign f1.i_rd_valid = rd_valid; assign f2.i_rd_valid = rd_valid;

  flash_test_gen #(.ADDR_W(24), .DATA_W(8), .NUM_W(9), .BURST(4), .PASSES(2),
                   .SECTOR(4096), .ERR_W(16)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(f1));
  flash_test_gen #(.ADDR_W(24), .DATA_W(8), .NUM_W(9), .BURST(4), .PASSES(2),
                   .SECTOR(4096), .ERR_W(2))  dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(f2));

  wire [65:0] outs1 = {f1.o_op_type, f1.o_op_addr, f1.o_op_num, f1.o_op_valid, f1.o_wr_data,
                       f1.o_wr_sop, f1.o_wr_eop, f1.o_wr_valid, f1.o_busy, f1.o_done,
                       f1.o_pass, f1.o_err_cnt};

  int checks = 0, passes = 0;

  logic [1:0]  lt [8];
  logic [23:0] la [8];
  logic [8:0]  ln [8];
  logic [7:0]  wd [16];
  logic        ws [16], we [16];
  int nops, nwr, tmo, hold_bad, overlap_bad, stall_bad, gap_bad;
  bit done_seen;
  logic pass_d, pass2_d, busy_mid, done_after, busy_after;
  logic [15:0] err_d;
  logic [1:0]  err2_d;

  logic [1:0]  et [6]  = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00};
  logic [23:0] ea [6]  = '{24'h0, 24'h0, 24'h0, 24'h1000, 24'h1000, 24'h1000};
  logic [8:0]  en [6]  = '{9'd0, 9'd4, 9'd4, 9'd0, 9'd4, 9'd4};
  logic [7:0]  ewd [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04};

  task automatic get_op(input int stall);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (f1.o_wr_valid && f1.o_op_valid) overlap_bad++;
      if (f1.o_op_valid && nops < 8) begin
        got = 1;
        lt[nops] = f1.o_op_type; la[nops] = f1.o_op_addr; ln[nops] = f1.o_op_num;
        if (stall > 0 && f1.o_op_type == 2'b01) begin
          for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (!f1.o_op_valid || f1.o_op_type !== lt[nops] || f1.o_op_addr !== la[nops] ||
                f1.o_op_num !== ln[nops]) stall_bad++;
          end
        end
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        if (f1.o_op_valid) gap_bad++;
        nops++;
      end
    end
    if (!got) tmo++;
  endtask

  task automatic get_write(input bit toggle);
    int cnt = 0;
    bit pend = 0;
    logic [7:0] pd = '0;
    for (int i = 0; i < 60 && cnt < 4; i++) begin
      @(negedge clk);
      if (f1.o_wr_valid && f1.o_op_valid) overlap_bad++;
      if (pend && f1.o_wr_data !== pd) hold_bad++;
      wr_ready = toggle ? (i % 2 == 1) : 1'b1;
      if (f1.o_wr_valid) begin
        if (wr_ready && nwr < 16) begin
          wd[nwr] = f1.o_wr_data; ws[nwr] = f1.o_wr_sop; we[nwr] = f1.o_wr_eop;
          nwr++; cnt++; pend = 0;
        end else begin
          pend = 1; pd = f1.o_wr_data;
        end
      end
    end
    @(negedge clk);
    wr_ready = 1'b0;
    if (f1.o_wr_valid) hold_bad++;
    if (cnt < 4) tmo++;
  endtask

  task automatic drive_read(input int n, input int bad_idx, input bit all_bad, input logic [7:0] base);
    logic [7:0] v;
    for (int jj = 0; jj < n; jj++) begin
      @(negedge clk);
      v = base + 8'(jj);
      if (jj == bad_idx) v = 8'hFF;
      if (all_bad) v = ~v;
      rd_valid = 1'b1; rd_sop = (jj == 0); rd_eop = (jj == n - 1); rd_data = v;
    end
    @(negedge clk);
    rd_valid = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0; rd_data = '0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !done_seen; i++) begin
      if (f1.o_done) begin
        done_seen = 1;
        pass_d = f1.o_pass; err_d = f1.o_err_cnt; pass2_d = f2.o_pass; err2_d = f2.o_err_cnt;
      end else @(negedge clk);
    end
    if (done_seen) begin
      @(negedge clk);
      done_after = f1.o_done; busy_after = f1.o_busy;
    end else tmo++;
  endtask

  task automatic run_flow(input int rd_mode, input bit wr_toggle, input int stall, input bit poke);
    nops = 0; nwr = 0; tmo = 0; hold_bad = 0; overlap_bad = 0; stall_bad = 0; gap_bad = 0;
    done_seen = 0; pass_d = 'x; err_d = 'x; pass2_d = 'x; err2_d = 'x;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int p = 0; p < 2; p++) begin
      int n;
      n = (rd_mode == 2 && p == 0) ? 3 : ((rd_mode == 3 && p == 0) ? 5 : 4);
      get_op(0);
      get_op(p == 0 ? stall : 0);
      get_write(wr_toggle);
      if (p == 0) busy_mid = f1.o_busy;
      if (poke && p == 0) start = 1'b1;
      get_op(0);
      drive_read(n, (rd_mode == 1 && p == 0) ? 2 : -1, rd_mode == 4, 8'(p));
      start = 1'b0;
    end
    wait_done();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; op_ready = 0; wr_ready = 0;
    rd_sop = 0; rd_eop = 0; rd_valid = 0; rd_data = '0;
    #12;
    checks++; if (outs1 !== '0) $display("FAIL reset_outputs got %h want 0", outs1); else passes++;
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (outs1 !== '0) $display("FAIL idle_after_release got %h want 0", outs1); else passes++;
    checks++; if (f2.o_err_cnt !== 2'd0) $display("FAIL reset_err2 got %0d want 0", f2.o_err_cnt); else passes++;
  endtask

  task automatic test_clean();
    run_flow(0, 0, 0, 0);
    checks++; if (tmo !== 0) $display("FAIL clean_timeout got %0d want 0", tmo); else passes++;
    checks++; if (nops !== 6) $display("FAIL clean_nops got %0d want 6", nops); else passes++;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({lt[i], la[i], ln[i]} !== {et[i], ea[i], en[i]})
        $display("FAIL clean_op%0d got %b/%h/%0d want %b/%h/%0d", i, lt[i], la[i], ln[i], et[i], ea[i], en[i]);
      else passes++;
    end
    checks++; if (nwr !== 8) $display("FAIL clean_nwr got %0d want 8", nwr); else passes++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({wd[i], ws[i], we[i]} !== {ewd[i], i % 4 == 0, i % 4 == 3})
        $display("FAIL clean_wr%0d got %h/%b/%b want %h/%b/%b", i, wd[i], ws[i], we[i], ewd[i], i % 4 == 0, i % 4 == 3);
      else passes++;
    end
    checks++; if (busy_mid !== 1'b1) $display("FAIL clean_busy_mid got %b want 1", busy_mid); else passes++;
    checks++; if (overlap_bad !== 0) $display("FAIL clean_overlap got %0d want 0", overlap_bad); else passes++;
    checks++; if (gap_bad !== 0) $display("FAIL clean_op_gap got %0d want 0", gap_bad); else passes++;
    checks++; if (done_seen !== 1'b1) $display("FAIL clean_done got %b want 1", done_seen); else passes++;
    checks++; if (pass_d !== 1'b1) $display("FAIL clean_pass got %b want 1", pass_d); else passes++;
    checks++; if (err_d !== 16'd0) $display("FAIL clean_err got %0d want 0", err_d); else passes++;
    checks++; if (done_after !== 1'b0) $display("FAIL clean_done_pulse got %b want 0", done_after); else passes++;
    checks++; if (busy_after !== 1'b0) $display("FAIL clean_busy_end got %b want 0", busy_after); else passes++;
  endtask

  task automatic test_corrupt();
    run_flow(1, 0, 0, 0);
    checks++; if (err_d !== 16'd1) $display("FAIL corrupt_err got %0d want 1", err_d); else passes++;
    checks++; if (pass_d !== 1'b0) $display("FAIL corrupt_pass got %b want 0", pass_d); else passes++;
  endtask

  task automatic test_burst_length();
    run_flow(2, 0, 0, 0);
    checks++; if (err_d !== 16'd1) $display("FAIL short_err got %0d want 1", err_d); else passes++;
    checks++; if (la[3] !== 24'h1000) $display("FAIL short_next_addr got %h want 001000", la[3]); else passes++;
    run_flow(3, 0, 0, 0);
    checks++; if (err_d !== 16'd2) $display("FAIL long_err got %0d want 2", err_d); else passes++;
    checks++; if (pass_d !== 1'b0) $display("FAIL long_pass got %b want 0", pass_d); else passes++;
  endtask

  task automatic test_back_to_back();
    run_flow(0, 1, 10, 0);
    checks++; if (tmo !== 0) $display("FAIL bp_timeout got %0d want 0", tmo); else passes++;
    checks++; if (stall_bad !== 0) $display("FAIL bp_op_stable got %0d want 0", stall_bad); else passes++;
    checks++; if (hold_bad !== 0) $display("FAIL bp_wr_hold got %0d want 0", hold_bad); else passes++;
    checks++; if (nwr !== 8) $display("FAIL bp_nwr got %0d want 8", nwr); else passes++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wd[i] !== ewd[i]) $display("FAIL bp_wr%0d got %h want %h", i, wd[i], ewd[i]); else passes++;
    end
    checks++; if (pass_d !== 1'b1) $display("FAIL bp_pass got %b want 1", pass_d); else passes++;
  endtask

  task automatic test_saturate();
    run_flow(4, 0, 0, 1);
    checks++; if (nops !== 6) $display("FAIL sat_nops got %0d want 6", nops); else passes++;
    checks++; if (la[3] !== 24'h1000) $display("FAIL sat_start_ignored got %h want 001000", la[3]); else passes++;
    checks++; if (err_d !== 16'd8) $display("FAIL sat_err16 got %0d want 8", err_d); else passes++;
    checks++; if (err2_d !== 2'd3) $display("FAIL sat_err2 got %0d want 3", err2_d); else passes++;
    checks++; if (pass2_d !== 1'b0) $display("FAIL sat_pass2 got %b want 0", pass2_d); else passes++;
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    nops = 0; tmo = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    get_op(0);
    get_op(0);
    wr_ready = 1'b1;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (f1.o_wr_valid && f1.o_wr_data == 8'd2) hit = 1;
    end
    checks++; if (hit !== 1'b1) $display("FAIL rst_mid_reach_beat2 got %b want 1", hit); else passes++;
    rst_n = 1'b0; wr_ready = 1'b0;
    #1;
    checks++; if (outs1 !== '0) $display("FAIL rst_mid_outputs got %h want 0", outs1); else passes++;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (outs1 !== '0) $display("FAIL rst_mid_quiet got %h want 0", outs1); else passes++;
    run_flow(0, 0, 0, 0);
    checks++;
    if ({lt[0], la[0], ln[0]} !== {2'b10, 24'h0, 9'd0})
      $display("FAIL rst_mid_first_op got %b/%h/%0d want 10/000000/0", lt[0], la[0], ln[0]);
    else passes++;
    checks++; if (wd[0] !== 8'h00) $display("FAIL rst_mid_wr0 got %h want 00", wd[0]); else passes++;
    checks++; if (pass_d !== 1'b1) $display("FAIL rst_mid_pass got %b want 1", pass_d); else passes++;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_corrupt();
    test_burst_length();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired passed=%0d total=%0d", passes, checks);
    $fatal(1, "watchdog");
  end
endmodule
